// File: rtl/vga_frame_scanout_if.sv
// Plot/clear bus between the drawing stage and the VGA frame scanout.
// The drawing side drives writes and clear; scanout reports clear progress.
interface vga_frame_scanout_if;
    logic       plot;
    logic [7:0] x;
    logic [6:0] y;
    logic [2:0] color;
    logic       clear;
    logic       clear_busy;

    modport master (
        output plot, x, y, color, clear,
        input  clear_busy
    );

    modport slave (
        input  plot, x, y, color, clear,
        output clear_busy
    );
endinterface

// File: rtl/vga_frame_scanout.sv
// 160x120x3 frame buffer with plot/clear writes, scanned out as 640x480@60.
// Each stored pixel is replicated 4x4 on screen.
module vga_frame_scanout #(
    parameter int CLK_DIV = 4,
    parameter int H_VIS   = 640,
    parameter int H_FP    = 16,
    parameter int H_SYNC  = 96,
    parameter int H_BP    = 48,
    parameter int V_VIS   = 480,
    parameter int V_FP    = 10,
    parameter int V_SYNC  = 2,
    parameter int V_BP    = 33
) (
    input  logic                  clk,
    input  logic                  reset,
    vga_frame_scanout_if.slave    pix,
    output logic                  vga_hs,
    output logic                  vga_vs,
    output logic [3:0]            vga_r,
    output logic [3:0]            vga_g,
    output logic [3:0]            vga_b,
    output logic                  frame_start
);

    localparam int H_TOT = H_VIS + H_FP + H_SYNC + H_BP;
    localparam int V_TOT = V_VIS + V_FP + V_SYNC + V_BP;
    localparam int DW    = $clog2(CLK_DIV);
    localparam int N_PIX = 19200;

    localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
    localparam logic [9:0] H_LAST  = 10'(H_TOT - 1);
    localparam logic [9:0] V_LAST  = 10'(V_TOT - 1);
    localparam logic [9:0] H_VIS_L = 10'(H_VIS);
    localparam logic [9:0] V_VIS_L = 10'(V_VIS);
    localparam logic [9:0] HS_BEG  = 10'(H_VIS + H_FP);
    localparam logic [9:0] HS_END  = 10'(H_VIS + H_FP + H_SYNC - 1);
    localparam logic [9:0] VS_BEG  = 10'(V_VIS + V_FP);
    localparam logic [9:0] VS_END  = 10'(V_VIS + V_FP + V_SYNC - 1);
    localparam logic [14:0] A_LAST = 15'(N_PIX - 1);

    typedef enum logic {
        IDLE,
        CLEAR
    } state_t;

    state_t      state;
    state_t      state_nxt;
    logic [14:0] clr_addr;
    logic [14:0] clr_addr_nxt;
    logic        busy;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= IDLE;
            clr_addr <= '0;
        end else begin
            state    <= state_nxt;
            clr_addr <= clr_addr_nxt;
        end
    end

    always_comb begin
        state_nxt    = state;
        clr_addr_nxt = clr_addr;
        busy         = 1'b0;
        unique case (state)
            IDLE: begin
                if (pix.clear) begin
                    state_nxt    = CLEAR;
                    clr_addr_nxt = '0;
                end
            end
            CLEAR: begin
                busy         = 1'b1;
                clr_addr_nxt = clr_addr + 15'd1;
                if (clr_addr == A_LAST) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    assign pix.clear_busy = busy;

    logic        plot_ok;
    logic [14:0] plot_addr;
    logic        wr_en;
    logic [14:0] wr_addr;
    logic [2:0]  wr_data;

    // A clear request in the same cycle as a plot takes priority.
    assign plot_ok = pix.plot && !pix.clear
                   && (pix.x < 8'd160) && (pix.y < 7'd120);

    assign plot_addr = ({8'd0, pix.y} << 7)
                     + ({8'd0, pix.y} << 5)
                     + {7'd0, pix.x};

    assign wr_en   = busy || plot_ok;
    assign wr_addr = busy ? clr_addr : plot_addr;
    assign wr_data = busy ? 3'b000 : pix.color;

    logic [DW-1:0] div;
    logic          tick;
    logic [9:0]    h_cnt;
    logic [9:0]    v_cnt;
    logic          vis;
    logic [6:0]    row;
    logic [7:0]    col;
    logic [14:0]   rd_addr;
    logic [2:0]    rd_data;

    assign tick = (div == DIV_LAST);
    assign vis  = (h_cnt < H_VIS_L) && (v_cnt < V_VIS_L);
    assign row  = v_cnt[8:2];
    assign col  = h_cnt[9:2];

    // Blanking positions map past the buffer, so park the read at 0.
    assign rd_addr = vis ? (({8'd0, row} << 7)
                          + ({8'd0, row} << 5)
                          + {7'd0, col})
                         : 15'd0;

    logic [2:0] mem [0:N_PIX-1];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
        rd_data <= mem[rd_addr];
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            div   <= '0;
            h_cnt <= '0;
            v_cnt <= '0;
        end else if (tick) begin
            div <= '0;
            if (h_cnt == H_LAST) begin
                h_cnt <= '0;
                if (v_cnt == V_LAST) begin
                    v_cnt <= '0;
                end else begin
                    v_cnt <= v_cnt + 10'd1;
                end
            end else begin
                h_cnt <= h_cnt + 10'd1;
            end
        end else begin
            div <= div + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            vga_hs      <= 1'b1;
            vga_vs      <= 1'b1;
            vga_r       <= '0;
            vga_g       <= '0;
            vga_b       <= '0;
            frame_start <= 1'b0;
        end else begin
            frame_start <= tick && (h_cnt == H_LAST)
                                && (v_cnt == V_LAST);
            if (tick) begin
                vga_hs <= !((h_cnt >= HS_BEG) && (h_cnt <= HS_END));
                vga_vs <= !((v_cnt >= VS_BEG) && (v_cnt <= VS_END));
                vga_r  <= (vis && rd_data[2]) ? 4'hF : 4'h0;
                vga_g  <= (vis && rd_data[1]) ? 4'hF : 4'h0;
                vga_b  <= (vis && rd_data[0]) ? 4'hF : 4'h0;
            end
        end
    end

endmodule
